// File: rtl/hack_mem_pkg.sv
// Shared types and address map for the Hack memory responder.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package hack_mem_pkg;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_SCREEN = 2'd1,
    REG_MMIO   = 2'd2,
    REG_NONE   = 2'd3
  } region_t;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] MMIO_BASE   = 15'h6000;

  localparam logic [1:0] MMIO_SW      = 2'd0;
  localparam logic [1:0] MMIO_KBD     = 2'd1;
  localparam logic [1:0] MMIO_CNT     = 2'd2;
  localparam logic [1:0] MMIO_SCRATCH = 2'd3;

  // Only 0x6000-0x6003 are mapped above the screen; everything else up there is a hole.
  function automatic region_t decode_region(input logic [14:0] addr);
    region_t r;
    if (addr < SCREEN_BASE)
      r = REG_RAM;
    else if (addr < MMIO_BASE)
      r = REG_SCREEN;
    else if (addr[12:2] == 11'd0)
      r = REG_MMIO;
    else
      r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/hack_mem_responder_if.sv
// CPU data-side bus: one write and one read address per cycle.
// Latency: in_m carries data for the read address of the previous cycle.
// Backpressure: none; the responder accepts every cycle.
interface hack_mem_responder_if;
  logic        write_m;
  logic [14:0] write_data_addr;
  logic [15:0] out_m;
  logic [14:0] read_data_addr;
  logic [15:0] in_m;

  modport master (
    output write_m, write_data_addr, out_m, read_data_addr,
    input  in_m
  );

  modport slave (
    input  write_m, write_data_addr, out_m, read_data_addr,
    output in_m
  );
endinterface

// File: rtl/hack_dp_ram.sv
// One write port, two synchronous read ports, read-before-write on a collision.
// Latency: read data valid one cycle after the read address.
// Backpressure: none; writes and reads are accepted every cycle.
module hack_dp_ram #(
  parameter  int DEPTH = 16384,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reads sample the array before this edge's write lands, giving old data on a collision.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/hack_mem_responder.sv
// Hack memory responder: data RAM, screen RAM with scanner port, and MMIO registers.
// Latency: in_m and disp_data one cycle after their address; writes land at cycle end.
// Backpressure: none; one write and one read accepted every cycle.
module hack_mem_responder
  import hack_mem_pkg::*;
#(
  parameter int DATA_WORDS   = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int SW_WIDTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  hack_mem_responder_if.slave cpu,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic [15:0]         kbd_code,
  input  logic                kbd_strobe,
  input  logic [12:0]         disp_addr,
  output logic [15:0]         disp_data,
  output logic                bad_write
);

  localparam int DAW = $clog2(DATA_WORDS);
  localparam int SAW = $clog2(SCREEN_WORDS);

  region_t       wr_reg, rd_reg, rd_sel_q;
  logic [1:0]    wr_off, rd_off;
  logic          ram_we, scr_we, mmio_we, wr_bad;
  logic [15:0]   ram_rd, scr_rd, scr_disp;
  logic [15:0]   mmio_rd, mmio_q;
  logic          disp_vld_q;

  logic [SW_WIDTH-1:0] sw_s1, sw_s2;
  logic [15:0]         kbd_reg;
  logic                kbd_pend;
  logic [15:0]         cyc_cnt;
  logic [15:0]         scratch;

  assign wr_reg  = decode_region(cpu.write_data_addr);
  assign rd_reg  = decode_region(cpu.read_data_addr);
  assign wr_off  = cpu.write_data_addr[1:0];
  assign rd_off  = cpu.read_data_addr[1:0];

  assign ram_we  = cpu.write_m && (wr_reg == REG_RAM);
  assign scr_we  = cpu.write_m && (wr_reg == REG_SCREEN);
  assign mmio_we = cpu.write_m && (wr_reg == REG_MMIO);
  // Switch and keyboard registers are read-only; writing them or a hole is flagged and dropped.
  assign wr_bad  = cpu.write_m &&
                   ((wr_reg == REG_NONE) ||
                    ((wr_reg == REG_MMIO) && ((wr_off == MMIO_SW) || (wr_off == MMIO_KBD))));

  hack_dp_ram #(.DEPTH(DATA_WORDS), .WIDTH(16)) u_data_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (cpu.write_data_addr[DAW-1:0]),
    .wdata   (cpu.out_m),
    .raddr_a (cpu.read_data_addr[DAW-1:0]),
    .rdata_a (ram_rd),
    .raddr_b ('0),
    .rdata_b ()
  );

  hack_dp_ram #(.DEPTH(SCREEN_WORDS), .WIDTH(16)) u_screen_ram (
    .clk     (clk),
    .we      (scr_we),
    .waddr   (cpu.write_data_addr[SAW-1:0]),
    .wdata   (cpu.out_m),
    .raddr_a (cpu.read_data_addr[SAW-1:0]),
    .rdata_a (scr_rd),
    .raddr_b (disp_addr[SAW-1:0]),
    .rdata_b (scr_disp)
  );

  // MMIO read value for the address presented this cycle; pending flag shows in bit 15.
  always_comb begin
    mmio_rd = '0;
    case (rd_off)
      MMIO_SW:      mmio_rd = 16'(sw_s2);
      MMIO_KBD:     mmio_rd = {kbd_pend, kbd_reg[14:0]};
      MMIO_CNT:     mmio_rd = cyc_cnt;
      MMIO_SCRATCH: mmio_rd = scratch;
      default:      mmio_rd = '0;
    endcase
  end

  // MMIO state, switch synchroniser, and the registered read-select / bad-write stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      kbd_reg    <= '0;
      kbd_pend   <= 1'b0;
      cyc_cnt    <= '0;
      scratch    <= '0;
      bad_write  <= 1'b0;
      rd_sel_q   <= REG_NONE;
      mmio_q     <= '0;
      disp_vld_q <= 1'b0;
    end else begin
      sw_s1      <= sw;
      sw_s2      <= sw_s1;
      bad_write  <= wr_bad;
      rd_sel_q   <= rd_reg;
      mmio_q     <= mmio_rd;
      disp_vld_q <= 1'b1;

      // A fresh scan code wins over a read that would clear the pending flag.
      if (kbd_strobe) begin
        kbd_reg  <= kbd_code;
        kbd_pend <= 1'b1;
      end else if ((rd_reg == REG_MMIO) && (rd_off == MMIO_KBD)) begin
        kbd_pend <= 1'b0;
      end

      if (mmio_we && (wr_off == MMIO_CNT))
        cyc_cnt <= cpu.out_m;
      else
        cyc_cnt <= cyc_cnt + 16'd1;

      if (mmio_we && (wr_off == MMIO_SCRATCH))
        scratch <= cpu.out_m;
    end
  end

  // Output mux over registered sources; the select resets to REG_NONE so in_m reads 0.
  always_comb begin
    cpu.in_m = '0;
    case (rd_sel_q)
      REG_RAM:    cpu.in_m = ram_rd;
      REG_SCREEN: cpu.in_m = scr_rd;
      REG_MMIO:   cpu.in_m = mmio_q;
      default:    cpu.in_m = '0;
    endcase
  end

  // RAM output is not reset, so hide it until the first post-reset read has completed.
  assign disp_data = disp_vld_q ? scr_disp : 16'h0000;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Directed self-checking bench for hack_mem_responder.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: n/a.
module tb_hack_mem_responder;

  logic        clk;
  logic        reset;
  logic [3:0]  sw;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
  logic        bad_write;

  int n_assert;
  int n_fail;

  hack_mem_responder_if bus ();

  hack_mem_responder #(
    .DATA_WORDS  (16384),
    .SCREEN_WORDS(8192),
    .SW_WIDTH    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .sw         (sw),
    .kbd_code   (kbd_code),
    .kbd_strobe (kbd_strobe),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .bad_write  (bad_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    bus.write_m         = 1'b1;
    bus.write_data_addr = a;
    bus.out_m           = d;
  endtask

  task automatic no_wr();
    bus.write_m = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    sw       = 4'hA;
    kbd_code = 16'h0000;
    kbd_strobe = 1'b0;
    disp_addr  = 13'd0;
    bus.write_m         = 1'b0;
    bus.write_data_addr = 15'h0000;
    bus.out_m           = 16'h0000;
    bus.read_data_addr  = 15'h0000;

    tick();
    tick();
    chk("reset_in_m", bus.in_m, 16'h0000);
    chk("reset_disp", disp_data, 16'h0000);
    chk("reset_bad", {15'd0, bad_write}, 16'h0000);
    reset = 1'b0;

    // Preload 0x0010 with 0x0001.
    wr(15'h0010, 16'h0001);
    tick();

    // Plain write then read.
    wr(15'h0005, 16'h1234);
    tick();
    no_wr();
    bus.read_data_addr = 15'h0005;
    tick();
    chk("ram_rd_after_wr", bus.in_m, 16'h1234);

    // Same-cycle read and write: old value, then new.
    wr(15'h0010, 16'hBEEF);
    bus.read_data_addr = 15'h0010;
    tick();
    chk("ram_rbw_old", bus.in_m, 16'h0001);
    no_wr();
    tick();
    chk("ram_rbw_new", bus.in_m, 16'hBEEF);

    // Screen write, scanner and CPU read.
    wr(15'h4003, 16'hAAAA);
    bus.read_data_addr = 15'h0000;
    tick();
    no_wr();
    disp_addr = 13'd3;
    bus.read_data_addr = 15'h4003;
    tick();
    chk("disp_rd", disp_data, 16'hAAAA);
    chk("scr_cpu_rd", bus.in_m, 16'hAAAA);

    // Scanner sees old word on a same-address write; concurrent RAM read serviced.
    wr(15'h4003, 16'h5555);
    bus.read_data_addr = 15'h0005;
    tick();
    chk("disp_rbw_old", disp_data, 16'hAAAA);
    chk("ram_rd_concurrent", bus.in_m, 16'h1234);
    no_wr();
    tick();
    chk("disp_rbw_new", disp_data, 16'h5555);

    // Keyboard: pending bit shows once, then clears.
    bus.read_data_addr = 15'h0000;
    kbd_code = 16'h0041;
    kbd_strobe = 1'b1;
    tick();
    kbd_strobe = 1'b0;
    bus.read_data_addr = 15'h6001;
    tick();
    chk("kbd_pend", bus.in_m, 16'h8041);
    tick();
    chk("kbd_clr", bus.in_m, 16'h0041);

    // Strobe coincident with a read: strobe wins, pending stays set.
    kbd_code = 16'h0042;
    kbd_strobe = 1'b1;
    tick();
    chk("kbd_coinc_rd", bus.in_m, 16'h0041);
    kbd_strobe = 1'b0;
    tick();
    chk("kbd_coinc_pend", bus.in_m, 16'h8042);

    // Cycle counter load and wrap.
    bus.read_data_addr = 15'h0000;
    wr(15'h6002, 16'hFFFE);
    tick();
    no_wr();
    tick();
    bus.read_data_addr = 15'h6002;
    tick();
    chk("cnt_load", bus.in_m, 16'hFFFF);
    bus.read_data_addr = 15'h0000;
    tick();
    bus.read_data_addr = 15'h6002;
    tick();
    chk("cnt_wrap", bus.in_m, 16'h0001);

    // Scratch register.
    bus.read_data_addr = 15'h0000;
    wr(15'h6003, 16'hC0DE);
    tick();
    chk("scratch_no_bad", {15'd0, bad_write}, 16'h0000);
    no_wr();
    bus.read_data_addr = 15'h6003;
    tick();
    chk("scratch_rd", bus.in_m, 16'hC0DE);

    // Bad writes pulse for one cycle and change nothing.
    wr(15'h6000, 16'hFFFF);
    bus.read_data_addr = 15'h6000;
    tick();
    chk("bad_6000", {15'd0, bad_write}, 16'h0001);
    chk("sw_rd", bus.in_m, 16'h000A);
    no_wr();
    tick();
    chk("bad_pulse_end", {15'd0, bad_write}, 16'h0000);
    wr(15'h7000, 16'h1234);
    tick();
    chk("bad_7000", {15'd0, bad_write}, 16'h0001);
    no_wr();
    tick();
    chk("bad_7000_end", {15'd0, bad_write}, 16'h0000);
    chk("sw_rd_after_bad", bus.in_m, 16'h000A);
    wr(15'h6004, 16'h1111);
    tick();
    chk("bad_6004", {15'd0, bad_write}, 16'h0001);
    no_wr();
    bus.read_data_addr = 15'h6003;
    tick();
    chk("scratch_kept", bus.in_m, 16'hC0DE);

    // Switch synchroniser delay.
    sw = 4'h5;
    bus.read_data_addr = 15'h6000;
    tick();
    chk("sw_sync_0", bus.in_m, 16'h000A);
    tick();
    chk("sw_sync_1", bus.in_m, 16'h000A);
    tick();
    chk("sw_sync_2", bus.in_m, 16'h0005);

    // Reset mid-stream drops the pending read.
    bus.read_data_addr = 15'h0005;
    tick();
    chk("pre_reset_rd", bus.in_m, 16'h1234);
    reset = 1'b1;
    tick();
    chk("reset_mid_in_m", bus.in_m, 16'h0000);
    chk("reset_mid_disp", disp_data, 16'h0000);
    reset = 1'b0;
    bus.read_data_addr = 15'h6002;
    tick();
    chk("cnt_after_reset", bus.in_m, 16'h0000);
    bus.read_data_addr = 15'h6001;
    tick();
    chk("kbd_after_reset", bus.in_m, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
